// File: rtl/adaptive_box_filter_if.sv
// adaptive_box_filter_if: image ROM read port and middle RAM write port bundle
interface adaptive_box_filter_if #(
  parameter int WIDTH_BITS  = 8,
  parameter int HEIGHT_BITS = 8
);
  logic [WIDTH_BITS-1:0]  oImageCol;
  logic [HEIGHT_BITS-1:0] oImageRow;
  logic [7:0]             iImageData;
  logic [WIDTH_BITS-1:0]  oResultCol;
  logic [HEIGHT_BITS-1:0] oResultRow;
  logic [7:0]             oResultData;
  logic                   oResultWren;
  modport master (
    output oImageCol, oImageRow, oResultCol, oResultRow, oResultData, oResultWren,
    input  iImageData
  );
  modport slave (
    input  oImageCol, oImageRow, oResultCol, oResultRow, oResultData, oResultWren,
    output iImageData
  );
endinterface

// File: rtl/adaptive_box_filter.sv
// adaptive_box_filter: edge-clamped (2R+1)^2 box mean or adaptive threshold, ROM to RAM
module adaptive_box_filter #(
  parameter int         WIDTH_BITS  = 8,
  parameter int         HEIGHT_BITS = 8,
  parameter int         RADIUS      = 1,
  parameter logic [2:0] STATE_ID    = 3'd1
) (
  input  logic                  clock,
  input  logic                  not_reset,
  input  logic [2:0]            global_state,
  input  logic [4:0]            C,
  input  logic                  iMode,
  output logic                  finished,
  adaptive_box_filter_if.master bus
);
  localparam int N     = (2 * RADIUS + 1) * (2 * RADIUS + 1);
  localparam int SUM_W = 8 + $clog2(N);
  localparam int RECIP = (65536 + N - 1) / N;
  localparam logic [2:0] DMAX = 3'(2 * RADIUS);
  localparam logic [2:0] CI   = 3'(RADIUS + 1);
  localparam logic [2:0] CJ   = 3'(RADIUS);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_BITS-1:0]  x_q, x_d, col_q, col_d;
  logic [HEIGHT_BITS-1:0] y_q, y_d, row_q, row_d;
  logic [2:0]             i_q, i_d, j_q, j_d;
  logic [SUM_W-1:0]       acc_q, acc_d, sum_n;
  logic [7:0]             center_q, center_d, data_q, data_d, mean;
  logic [4:0]             c_q, c_d;
  logic                   mode_q, mode_d, wren_q, wren_d, fin_q, fin_d, en, hit;
  logic [SUM_W+15:0]      prod;
  logic signed [9:0]      bound;

  function automatic int clampi(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction

  assign en    = global_state == STATE_ID;
  assign sum_n = acc_q + SUM_W'(bus.iImageData);
  assign prod  = (SUM_W+16)'(sum_n) * (SUM_W+16)'(RECIP);
  assign mean  = prod[23:16];
  assign bound = $signed({2'b00, mean}) - $signed({5'b00000, c_q});
  assign hit   = $signed({2'b00, center_q}) > bound;

  // The window counters (i, j) always hold the sample whose address is on the bus;
  // its data arrives one cycle later, hence the accumulate/capture offsets.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    center_d = center_q;
    mode_d   = mode_q;
    c_d      = c_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    case (state_q)
      IDLE: if (en) begin
        state_d = READ;
        x_d     = '0;
        y_d     = '0;
        i_d     = '0;
        j_d     = '0;
        acc_d   = '0;
        mode_d  = iMode;
        c_d     = C;
      end
      READ: if (!en) state_d = IDLE;
      else begin
        if (|i_q || |j_q) acc_d = sum_n;
        if (i_q == CI && j_q == CJ) center_d = bus.iImageData;
        if (i_q == DMAX && j_q == DMAX) state_d = DRAIN;
        else begin
          i_d = i_q == DMAX ? 3'd0 : i_q + 3'd1;
          j_d = i_q == DMAX ? j_q + 3'd1 : j_q;
        end
      end
      DRAIN: if (!en) state_d = IDLE;
      else begin
        acc_d   = sum_n;
        state_d = WRITE;
        wren_d  = 1'b1;
        data_d  = mode_q ? (hit ? 8'hFF : 8'h00) : mean;
      end
      WRITE: if (!en) state_d = IDLE;
      else begin
        acc_d   = '0;
        i_d     = '0;
        j_d     = '0;
        x_d     = x_q + WIDTH_BITS'(1);
        y_d     = &x_q ? y_q + HEIGHT_BITS'(1) : y_q;
        state_d = (&x_q && &y_q) ? DONE : READ;
      end
      DONE: if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    fin_d = state_d == DONE;
    col_d = WIDTH_BITS'(clampi(int'(x_d) + int'(i_d) - RADIUS, (1 << WIDTH_BITS) - 1));
    row_d = HEIGHT_BITS'(clampi(int'(y_d) + int'(j_d) - RADIUS, (1 << HEIGHT_BITS) - 1));
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      center_q <= '0;
      mode_q   <= 1'b0;
      c_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      center_q <= center_d;
      mode_q   <= mode_d;
      c_q      <= c_d;
      col_q    <= col_d;
      row_q    <= row_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      fin_q    <= fin_d;
    end
  end

  assign bus.oImageCol   = col_q;
  assign bus.oImageRow   = row_q;
  assign bus.oResultCol  = x_q;
  assign bus.oResultRow  = y_q;
  assign bus.oResultData = data_q;
  assign bus.oResultWren = wren_q;
  assign finished        = fin_q;
endmodule
